uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial UART receiver; consumes the line driven by the board's uart_tx (8N1, LSB first, idle high).
//  Synchronises rx_i, validates the start bit at mid-bit, samples each data bit at mid-bit and checks the stop bit.
//  Delivers one received word per frame as a single-cycle strobe to downstream logic.
//  Bit period matches uart_tx: BIT_CYC = PSCALER*DIV sysclk cycles; HALF = BIT_CYC/2 (integer division).
// PARAMETERS
//  N        8   data bits per frame
//  PSCALER  1   prescaler; bit period factor, same meaning as in uart_tx
//  DIV      10  bit period factor; BIT_CYC = PSCALER*DIV, legal range 4..65535 (16-bit counter)
// PORTS
//  sysclk      in   1  system clock; all logic on rising edge
//  reset_n     in   1  asynchronous, active-low reset
//  parity_i    in   1  parity select, 0=even, 1=odd; ignored unless UART_RX_PARITY_EN is defined
//  rx_i        in   1  asynchronous serial input, idle high
//  rx_data_o   out  N  last correctly received word, LSB = first bit on the line
//  rx_valid_o  out  1  one-cycle strobe; rx_data_o updated in the same cycle
//  rx_err_o    out  1  one-cycle strobe; framing error (stop bit = 0) or parity error
//  rx_busy_o   out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, sync FFs=1, bit_cnt=0, cyc_cnt=0, shift=0, rx_data_o=0,
//   rx_valid_o=0, rx_err_o=0, rx_busy_o=0. Reset mid-frame discards the partial word.
//  rx_i passes through a 2-FF synchroniser -> rx_s; all decisions use rx_s only.
//  cyc_cnt is 16-bit. It is cleared on every state change and on every bit sample.
//  IDLE:  rx_s==0 -> START, cyc_cnt=0.
//  START: when cyc_cnt==HALF-1, sample rx_s:
//   - rx_s==1: glitch; go to IDLE with no strobe.
//   - rx_s==0: go to DATA, bit_cnt=0.
//  DATA:  when cyc_cnt==BIT_CYC-1, sample rx_s into shift (shift right, new bit enters MSB) and bit_cnt++.
//   After bit N-1 is sampled: go to PARITY if the macro is defined, otherwise to STOP.
//  STOP:  when cyc_cnt==BIT_CYC-1, sample rx_s:
//   - rx_s==1: rx_data_o<=shift, rx_valid_o=1 for one cycle, go to IDLE.
//   - rx_s==0: rx_err_o=1 for one cycle, rx_data_o unchanged, go to BREAK.
//  BREAK: wait for rx_s==1, then go to IDLE. A held-low line never produces a spurious frame.
//  Sampling points are mid-bit. IDLE is re-entered mid-stop-bit, so a start edge immediately
//   after the stop bit is caught (back-to-back frames supported).
//  rx_valid_o and rx_err_o are never high in the same cycle; both are 0 in every other cycle.
//  There is no back-pressure. The consumer must capture rx_data_o on rx_valid_o; rx_data_o holds
//   until the next valid frame.
//  Latency: rx_valid_o rises 2 + HALF + N*BIT_CYC + BIT_CYC cycles (+BIT_CYC with parity)
//   after the rx_i falling edge, within +/-1 cycle.
//  State encoding is one-hot with a safe default: an illegal state goes to IDLE.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: adds a PARITY state between DATA and STOP.
//   - At cyc_cnt==BIT_CYC-1, sample the parity bit; expected = ^shift ^ parity_i.
//   - On mismatch, set a pending flag. At the end of STOP: rx_err_o=1 instead of rx_valid_o,
//     and rx_data_o is not updated.
//   - Framing error takes the same path, including BREAK.
//  UART_RX_PARITY_EN undefined: frame is 8N1. parity_i is unused; the PARITY state and flag are absent.
// TESTING (PSCALER=1, DIV=10 -> BIT_CYC=10, HALF=5)
//  1. Frame 0xA5, 10 cycles/bit -> one rx_valid_o pulse, rx_data_o=0xA5, rx_err_o stays 0,
//     rx_busy_o falls back to 0.
//  2. rx_i low for 3 cycles then high -> no strobe, return to IDLE; a following 0x3C is received correctly.
//  3. Frame 0x55 with stop bit 0, line held low 30 cycles, then high -> one rx_err_o pulse,
//     rx_data_o unchanged, no valid; a following 0x81 gives valid with 0x81.
//  4. reset_n asserted after 4 data bits of 0x0F -> all outputs 0 immediately (async);
//     after release, 0xFF is received correctly.
//  5. Loopback from uart_tx (same PSCALER/DIV), back-to-back 0x00,0xFF,0x5A -> three valids in order,
//     no errors.
//  6. UART_RX_PARITY_EN, parity_i=0: 0x07 with parity bit 1 -> valid 0x07;
//     0x07 with parity bit 0 -> rx_err_o pulse, rx_data_o unchanged.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, stop/framing check, one-cycle strobes.
// Optional parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx #(
   parameter int unsigned N       = 8,
   parameter int unsigned PSCALER = 1,
   parameter int unsigned DIV     = 10
) (
   input  logic         sysclk,
   input  logic         reset_n,
   input  logic         parity_i,
   input  logic         rx_i,
   output logic [N-1:0] rx_data_o,
   output logic         rx_valid_o,
   output logic         rx_err_o,
   output logic         rx_busy_o
);

   localparam int unsigned BIT_CYC = PSCALER * DIV;
   localparam int unsigned HALF    = BIT_CYC / 2;
   localparam int unsigned CW      = $clog2(N + 1);
   localparam logic [15:0]   HALF_M1 = 16'(HALF - 1);
   localparam logic [15:0]   BIT_M1  = 16'(BIT_CYC - 1);
   localparam logic [CW-1:0] LAST    = CW'(N - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [5:0] {
      S_IDLE   = 6'b000001,
      S_START  = 6'b000010,
      S_DATA   = 6'b000100,
      S_PARITY = 6'b001000,
      S_STOP   = 6'b010000,
      S_BREAK  = 6'b100000
   } state_e;
`else
   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_START = 5'b00010,
      S_DATA  = 5'b00100,
      S_STOP  = 5'b01000,
      S_BREAK = 5'b10000
   } state_e;
`endif

   state_e        state_q, state_d;
   logic          sync1_q, sync2_q;
   logic [15:0]   cyc_cnt_q, cyc_cnt_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [N-1:0]  shift_q, shift_d;
   logic [N-1:0]  rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_err_q, rx_err_d;
   logic          rx_busy_q, rx_busy_d;
   logic          rx_s;
   logic          par_bad;

`ifdef UART_RX_PARITY_EN
   logic par_err_q, par_err_d;
   assign par_bad = par_err_q;
`else
   logic unused_parity;
   assign unused_parity = parity_i;
   assign par_bad       = 1'b0;
`endif

   assign rx_s = sync2_q;

   always_comb begin
      state_d    = state_q;
      cyc_cnt_d  = cyc_cnt_q + 16'd1;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_d  = par_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            cyc_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            par_err_d = 1'b0;
`endif
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (cyc_cnt_q == HALF_M1) begin
               cyc_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cyc_cnt_q == BIT_M1) begin
               cyc_cnt_d = '0;
               shift_d   = {rx_s, shift_q[N-1:1]};
               bit_cnt_d = bit_cnt_q + CW'(1);
               if (bit_cnt_q == LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cyc_cnt_q == BIT_M1) begin
               cyc_cnt_d = '0;
               par_err_d = rx_s != (^shift_q ^ parity_i);
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cyc_cnt_q == BIT_M1) begin
               cyc_cnt_d = '0;
               // Parity failure with a good stop bit still returns straight to IDLE.
               if (rx_s && !par_bad) begin
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  rx_err_d = 1'b1;
               end
               state_d = rx_s ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            cyc_cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: begin
            cyc_cnt_d = '0;
            state_d   = S_IDLE;
         end
      endcase
      rx_busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         cyc_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         rx_busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sync1_q    <= rx_i;
         sync2_q    <= sync1_q;
         cyc_cnt_q  <= cyc_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_err_q   <= rx_err_d;
         rx_busy_q  <= rx_busy_d;
`ifdef UART_RX_PARITY_EN
         par_err_q  <= par_err_d;
`endif
      end
   end

   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign rx_err_o   = rx_err_q;
   assign rx_busy_o  = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (PSCALER=1, DIV=10); parity frames only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

   localparam int unsigned BIT = 10;
   localparam int unsigned HALF = 5;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned LAT = 2 + HALF + 8 * BIT + BIT + BIT;
`else
   localparam int unsigned LAT = 2 + HALF + 8 * BIT + BIT;
`endif

   logic       sysclk = 1'b0;
   logic       reset_n;
   logic       parity_i;
   logic       rx_i;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       rx_err_o;
   logic       rx_busy_o;

   int checks   = 0;
   int failures = 0;
   int vcnt = 0;
   int ecnt = 0;
   int both = 0;
   int cyc  = 0;
   int vcyc = 0;
   int t0   = 0;
   logic [7:0] vq[$];

   uart_rx #(.N(8), .PSCALER(1), .DIV(10)) dut (
      .sysclk     (sysclk),
      .reset_n    (reset_n),
      .parity_i   (parity_i),
      .rx_i       (rx_i),
      .rx_data_o  (rx_data_o),
      .rx_valid_o (rx_valid_o),
      .rx_err_o   (rx_err_o),
      .rx_busy_o  (rx_busy_o)
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) cyc++;

   always @(negedge sysclk) begin
      if (rx_valid_o) begin
         vq.push_back(rx_data_o);
         vcnt++;
         vcyc = cyc;
      end
      if (rx_err_o) ecnt++;
      if (rx_valid_o && rx_err_o) both++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      rx_i = 1'b1;
      repeat (n) @(negedge sysclk);
   endtask

   task automatic send_bit(input logic b);
      rx_i = b;
      repeat (BIT) @(negedge sysclk);
   endtask

   task automatic send_data(input logic [7:0] d);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
   endtask

   // Even-parity bit for parity_i=0 is simply the XOR of the data bits.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      send_data(d);
`ifdef UART_RX_PARITY_EN
      send_bit(par);
`endif
      send_bit(stop);
   endtask

   initial begin
      reset_n  = 1'b0;
      rx_i     = 1'b1;
      parity_i = 1'b0;
      repeat (3) @(negedge sysclk);
      check_eq("rst_data",  rx_data_o,  8'h00);
      check_eq("rst_valid", rx_valid_o, 1'b0);
      check_eq("rst_err",   rx_err_o,   1'b0);
      check_eq("rst_busy",  rx_busy_o,  1'b0);
      reset_n = 1'b1;
      idle(5);

      // 1: single good frame plus latency from the falling edge
      t0 = cyc;
      send_frame(8'hA5, 1'b0, 1'b1);
      idle(5);
      check_eq("t1_vcnt", vcnt, 1);
      check_eq("t1_data", rx_data_o, 8'hA5);
      check_eq("t1_ecnt", ecnt, 0);
      check_eq("t1_busy", rx_busy_o, 1'b0);
      check_eq("t1_lat",  vcyc - t0, LAT + 1);

      // 2: 3-cycle glitch rejected, then a real frame
      rx_i = 1'b0;
      repeat (3) @(negedge sysclk);
      idle(15);
      check_eq("t2_glitch_vcnt", vcnt, 1);
      check_eq("t2_glitch_ecnt", ecnt, 0);
      check_eq("t2_glitch_busy", rx_busy_o, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b1);
      idle(5);
      check_eq("t2_vcnt", vcnt, 2);
      check_eq("t2_data", rx_data_o, 8'h3C);

      // 3: framing error with line held low, then recovery
      send_data(8'h55);
`ifdef UART_RX_PARITY_EN
      send_bit(1'b0);
`endif
      rx_i = 1'b0;
      repeat (BIT + 30) @(negedge sysclk);
      check_eq("t3_break_busy", rx_busy_o, 1'b1);
      check_eq("t3_ecnt", ecnt, 1);
      check_eq("t3_vcnt", vcnt, 2);
      check_eq("t3_data", rx_data_o, 8'h3C);
      idle(5);
      check_eq("t3_idle_busy", rx_busy_o, 1'b0);
      check_eq("t3_held_ecnt", ecnt, 1);
      send_frame(8'h81, 1'b0, 1'b1);
      idle(5);
      check_eq("t3_vcnt2", vcnt, 3);
      check_eq("t3_data2", rx_data_o, 8'h81);

      // 4: async reset in the middle of 0x0F
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      check_eq("t4_busy_pre", rx_busy_o, 1'b1);
      reset_n = 1'b0;
      #1;
      check_eq("t4_data",  rx_data_o,  8'h00);
      check_eq("t4_busy",  rx_busy_o,  1'b0);
      check_eq("t4_valid", rx_valid_o, 1'b0);
      check_eq("t4_err",   rx_err_o,   1'b0);
      rx_i = 1'b1;
      repeat (3) @(negedge sysclk);
      reset_n = 1'b1;
      idle(5);
      check_eq("t4_vcnt_hold", vcnt, 3);
      send_frame(8'hFF, 1'b0, 1'b1);
      idle(5);
      check_eq("t4_vcnt", vcnt, 4);
      check_eq("t4_data2", rx_data_o, 8'hFF);

      // 5: back-to-back frames with no idle gap
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      send_frame(8'h5A, 1'b0, 1'b1);
      idle(5);
      check_eq("t5_vcnt", vcnt, 7);
      check_eq("t5_w0", vq[4], 8'h00);
      check_eq("t5_w1", vq[5], 8'hFF);
      check_eq("t5_w2", vq[6], 8'h5A);
      check_eq("t5_ecnt", ecnt, 1);

`ifdef UART_RX_PARITY_EN
      // 6: even parity, good then bad parity bit
      parity_i = 1'b0;
      send_frame(8'h07, 1'b1, 1'b1);
      idle(5);
      check_eq("t6_vcnt", vcnt, 8);
      check_eq("t6_data", rx_data_o, 8'h07);
      check_eq("t6_ecnt", ecnt, 1);
      send_frame(8'h70, 1'b1, 1'b1);
      idle(5);
      check_eq("t6_vcnt2", vcnt, 9);
      check_eq("t6_data2", rx_data_o, 8'h70);
      send_frame(8'h07, 1'b0, 1'b1);
      idle(5);
      check_eq("t6_perr_ecnt", ecnt, 2);
      check_eq("t6_perr_vcnt", vcnt, 9);
      check_eq("t6_perr_data", rx_data_o, 8'h70);
      check_eq("t6_perr_busy", rx_busy_o, 1'b0);
`endif

      check_eq("never_both", both, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
